// File: rtl/vec_lane_wb_stage.sv
// Vector lane writeback stage: masks lanes, reduces flags,
// and buffers beats through a two-entry valid/ready skid buffer.
module vec_lane_wb_stage #(
    parameter int LANES = 4,
    parameter int W     = 16,
    parameter int RD_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_result,
    input  logic [LANES*4-1:0] in_flags,
    input  logic               in_scalar,
    input  logic [RD_W-1:0]    in_rd,
    input  logic               in_we,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_result,
    output logic [LANES-1:0]   out_lane_mask,
    output logic [3:0]         out_flags,
    output logic [RD_W-1:0]    out_rd,
    output logic [15:0]        ovf_count,
    input  logic               ovf_clr
);

    typedef struct packed {
        logic               valid;
        logic [LANES*W-1:0] result;
        logic [LANES-1:0]   mask;
        logic [3:0]         flags;
        logic [RD_W-1:0]    rd;
    } beat_t;

    beat_t            m_q;
    beat_t            s_q;
    beat_t            cap;
    logic [LANES-1:0] act;
    logic             accept;
    logic             pop;

    assign in_ready = ~s_q.valid;
    assign accept   = in_valid & in_ready;
    assign pop      = m_q.valid & out_ready;

    // Capture transform: zero inactive lanes, reduce flags over active lanes.
    always_comb begin
        cap       = '0;
        cap.valid = 1'b1;
        cap.rd    = in_rd;
        act       = in_scalar ? LANES'(1) : '1;
        cap.mask  = in_we ? act : '0;
        cap.flags = 4'b0010;
        for (int i = 0; i < LANES; i++) begin
            if (act[i]) begin
                cap.result[i*W +: W] = in_result[i*W +: W];
                cap.flags[3] = cap.flags[3] | in_flags[i*4+3];
                cap.flags[2] = cap.flags[2] | in_flags[i*4+2];
                cap.flags[1] = cap.flags[1] & in_flags[i*4+1];
                cap.flags[0] = cap.flags[0] | in_flags[i*4+0];
            end
        end
    end

    // Skid buffer: M feeds the outputs, S absorbs one beat under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else if (s_q.valid) begin
            if (pop) begin
                m_q <= s_q;
                s_q <= '0;
            end
        end else if (accept) begin
            if (!m_q.valid || pop) begin
                m_q <= cap;
            end else begin
                s_q <= cap;
            end
        end else if (pop) begin
            m_q <= '0;
        end
    end

    // Saturating overflow-event counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (accept && cap.flags[3] && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

    assign out_valid     = m_q.valid;
    assign out_result    = m_q.result;
    assign out_lane_mask = m_q.mask;
    assign out_flags     = m_q.flags;
    assign out_rd        = m_q.rd;

endmodule

// File: doc/vec_lane_wb_stage.md
Name: vec_lane_wb_stage

Overview:
Registered writeback stage directly downstream of the per-lane vector ALU instances. It captures the combinational 16-bit lane results and 4-bit lane flags and masks the inactive lanes in scalar mode. It reduces the per-lane flags to one vector flag word and hands the beat to the register-file write port through a valid/ready skid buffer. It also keeps a saturating count of overflow events for debug.

Parameters:
LANES, 4, number of ALU lanes in the vector datapath
W, 16, lane data width (fixed-point word)
RD_W, 4, destination vector register index width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_result  in  LANES*W  lane results; lane i at [i*W +: W]
in_flags  in  LANES*4  lane flags {ovf,neg,zero,carry}; lane i at [i*4 +: 4]
in_scalar  in  1  scalar op; only lane 0 is meaningful
in_rd  in  RD_W  destination register index
in_we  in  1  beat writes the register file
out_valid  out  1  beat available to writeback
out_ready  in  1  writeback consumes the beat
out_result  out  LANES*W  masked lane results
out_lane_mask  out  LANES  per-lane write enable
out_flags  out  4  reduced flags {ovf,neg,zero,carry}
out_rd  out  RD_W  destination index
ovf_count  out  16  saturating count of accepted beats with reduced ovf=1
ovf_clr  in  1  synchronous clear of ovf_count

Behaviour:
- Reset, asynchronous, active-high: out_valid=0, in_ready=1, out_result=0, out_lane_mask=0, out_flags=0, out_rd=0, ovf_count=0. Both buffer entries are invalidated. A reset mid-transfer drops all buffered beats.
- Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register M drives the outputs and out_valid=M.valid. Skid register S holds one extra beat.
- in_ready = ~S.valid. It is registered and does not depend combinationally on out_ready.
- Next-state rules, evaluated in order:
  - S.valid & pop: M<=S, S cleared.
  - S.valid & ~pop: hold both entries.
  - ~S.valid & accept & (~M.valid | pop): M<=captured input.
  - ~S.valid & accept & M.valid & ~pop: S<=captured input.
  - ~S.valid & ~accept & pop: M cleared.
- Latency and ordering: 1 cycle from accept to out_valid when M is empty. Sustained throughput is 1 beat/cycle with out_ready=1. Order is strictly FIFO.
- Capture transform, applied at accept time:
  - Active lane mask act = in_scalar ? 1 (lane 0 only) : all ones.
  - out_lane_mask = in_we ? act : 0.
  - Inactive lane results are stored as 0. Undefined lane values must never propagate.
- Flag reduction over active lanes:
  - carry = OR
  - neg = OR
  - ovf = OR
  - zero = AND (all active lanes zero)
  - Scalar mode gives exactly lane 0's flags.
- out_rd equals in_rd of the same beat.
- ovf_count:
  - Increments by 1 on each accept whose reduced ovf=1.
  - Saturates at 16'hFFFF.
  - ovf_clr has priority over an increment in the same cycle; the count becomes 0.
- Beats with in_we=0 are still buffered and presented, with lane mask 0. Their flags still update ovf_count.
- out_* signals are stable while out_valid=1 & out_ready=0.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, ovf_count=0. Assert rst mid-stream with 2 beats buffered -> next cycle out_valid=0, in_ready=1.
- Vector beat, lanes {0x0100,0x0000,0xFF00,0x0200}, flags {0,2,4,0} (zero on lane1, neg on lane2), rd=3, we=1, out_ready=1 -> one cycle later out_result equals input, mask=4'b1111, out_flags=4'b0100, out_rd=3.
- Scalar beat, lane0=0x0000 with flags zero=1, lanes1-3=0xFFFF with flags 4'b1111 -> out_result lanes1-3=0, mask=4'b0001, out_flags=4'b0010.
- Backpressure: out_ready=0, send beats A,B,C back to back -> A in M, B in S, in_ready=0 before C is accepted. Raise out_ready -> output sequence A,B,C, with C accepted only after in_ready returns to 1. No loss or duplication.
- Streaming: 20 beats, in_valid=1, out_ready=1 -> 20 outputs in 20 consecutive cycles after 1-cycle latency, in_ready=1 throughout.
- Overflow counter: preload with 0xFFFE worth of accepts (or force), accept 3 beats with lane ovf set -> count saturates at 0xFFFF. ovf_clr asserted together with an ovf beat -> count=0.
